// File: rtl/cpu_paddle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_paddle_ctrl_if
//  Description : Bundle between the computer paddle controller and its
//                surroundings: play control, ball Y and human commands in,
//                paddle position, sampled target and motion flags out.
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_paddle_ctrl_if #(
  parameter int Y_W = 10
) ();

  logic           game_on;
  logic [1:0]     diff;
  logic [Y_W-1:0] ball_y;
  logic           human_up;
  logic           human_down;
  logic           wrap_en;
  logic [Y_W-1:0] position;
  logic [Y_W-1:0] target;
  logic           moving_up;
  logic           moving_down;

  // Game/physics side: drives the controls, observes the paddle
  modport master (
    output game_on, diff, ball_y, human_up, human_down, wrap_en,
    input  position, target, moving_up, moving_down
  );

  // Paddle controller side
  modport slave (
    input  game_on, diff, ball_y, human_up, human_down, wrap_en,
    output position, target, moving_up, moving_down
  );

endinterface
`default_nettype wire

// File: rtl/cpu_paddle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_paddle_ctrl
//  Description : Computer-player paddle controller with integrated position
//                counter. Tracks a periodically sampled ball Y with a
//                deadband, or mirrors the human's up/down commands; step rate
//                and reaction interval depend on the latched difficulty.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_paddle_ctrl #(
  parameter int Y_W          = 10,
  parameter int POS_MIN      = 32,
  parameter int POS_MAX      = 447,
  parameter int POS_RESET    = 240,
  parameter int DEADBAND     = 2,
  parameter int TICK_W       = 20,
  parameter int TICKS_MIRROR = 20000,
  parameter int TICKS_EASY   = 80000,
  parameter int TICKS_MED    = 40000,
  parameter int TICKS_HARD   = 20000,
  parameter int REACT_W      = 24,
  parameter int REACT_EASY   = 2000000,
  parameter int REACT_MED    = 1000000,
  parameter int REACT_HARD   = 250000
) (
  input  logic              clk,
  input  logic              reset,
  cpu_paddle_ctrl_if.slave  bus
);

  localparam logic [Y_W-1:0] MIN_Y   = Y_W'(POS_MIN);
  localparam logic [Y_W-1:0] MAX_Y   = Y_W'(POS_MAX);
  localparam logic [Y_W-1:0] RESET_Y = Y_W'(POS_RESET);
  localparam logic [Y_W:0]   DB_EXT  = (Y_W+1)'(DEADBAND);
  localparam logic [1:0]     DIFF_MIRROR = 2'b00;
  localparam logic [1:0]     DIFF_EASY   = 2'b01;
  localparam logic [1:0]     DIFF_MED    = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

  state_t             state_q, state_d;
  logic [1:0]         diff_q, diff_d;
  logic [Y_W-1:0]     position_q, position_d;
  logic [Y_W-1:0]     target_q, target_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [REACT_W-1:0] react_q, react_d;
  logic               moving_up_q, moving_up_d;
  logic               moving_down_q, moving_down_d;

  logic [TICK_W-1:0]  ticks_lim;
  logic [REACT_W-1:0] react_lim;
  logic               run;
  dir_t               dir_raw;
  dir_t               dir;
  dir_t               dir_prev;
  logic [TICK_W-1:0]  tick_eff;
  logic [Y_W-1:0]     pos_step;
  logic [Y_W:0]       pos_ext;
  logic [Y_W:0]       tgt_ext;

  // Terminal counts for the latched difficulty
  always_comb begin
    case (diff_q)
      DIFF_MIRROR: begin
        ticks_lim = TICK_W'(TICKS_MIRROR - 1);
        react_lim = '0;
      end
      DIFF_EASY: begin
        ticks_lim = TICK_W'(TICKS_EASY - 1);
        react_lim = REACT_W'(REACT_EASY - 1);
      end
      DIFF_MED: begin
        ticks_lim = TICK_W'(TICKS_MED - 1);
        react_lim = REACT_W'(REACT_MED - 1);
      end
      default: begin
        ticks_lim = TICK_W'(TICKS_HARD - 1);
        react_lim = REACT_W'(REACT_HARD - 1);
      end
    endcase
  end

  assign run      = (state_q == ST_ACTIVE) && bus.game_on;
  assign pos_ext  = {1'b0, position_q};
  assign tgt_ext  = {1'b0, target_q};
  // Last cycle's post-block direction is exactly what the flags hold
  assign dir_prev = dir_t'({moving_down_q, moving_up_q});

  // Requested direction, then limit blocking and the play gate
  always_comb begin
    dir_raw = DIR_NONE;
    if (diff_q == DIFF_MIRROR) begin
      if (bus.human_up && !bus.human_down) begin
        dir_raw = DIR_UP;
      end else if (bus.human_down && !bus.human_up) begin
        dir_raw = DIR_DOWN;
      end
    end else begin
      if ((tgt_ext + DB_EXT) < pos_ext) begin
        dir_raw = DIR_UP;
      end else if (tgt_ext > (pos_ext + DB_EXT)) begin
        dir_raw = DIR_DOWN;
      end
    end

    dir = dir_raw;
    if (!bus.wrap_en) begin
      if ((position_q == MIN_Y) && (dir_raw == DIR_UP)) begin
        dir = DIR_NONE;
      end
      if ((position_q == MAX_Y) && (dir_raw == DIR_DOWN)) begin
        dir = DIR_NONE;
      end
    end
    if (!run) begin
      dir = DIR_NONE;
    end
  end

  // A direction change restarts the count so this cycle counts as tick 0
  always_comb begin
    tick_eff = tick_q;
    if (dir != dir_prev) begin
      tick_eff = '0;
    end
  end

  // Position after one step: out-of-range snaps to the nearer limit first
  always_comb begin
    pos_step = position_q;
    if (position_q < MIN_Y) begin
      pos_step = MIN_Y;
    end else if (position_q > MAX_Y) begin
      pos_step = MAX_Y;
    end else if (dir == DIR_UP) begin
      pos_step = (position_q == MIN_Y) ? MAX_Y : (position_q - Y_W'(1));
    end else if (dir == DIR_DOWN) begin
      pos_step = (position_q == MAX_Y) ? MIN_Y : (position_q + Y_W'(1));
    end
  end

  // Next-state logic: FSM, counters, sampler, position and flags
  always_comb begin
    state_d       = state_q;
    diff_d        = bus.game_on ? diff_q : bus.diff;
    position_d    = position_q;
    target_d      = target_q;
    tick_d        = tick_q;
    react_d       = react_q;
    moving_up_d   = 1'b0;
    moving_down_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tick_d  = '0;
        react_d = '0;
        if (bus.game_on) begin
          state_d  = ST_ACTIVE;
          target_d = bus.ball_y;
        end
      end
      default: begin
        if (!bus.game_on) begin
          state_d = ST_IDLE;
          tick_d  = '0;
          react_d = '0;
        end else begin
          moving_up_d   = (dir == DIR_UP);
          moving_down_d = (dir == DIR_DOWN);

          if (dir == DIR_NONE) begin
            tick_d = '0;
          end else if (tick_eff == ticks_lim) begin
            tick_d     = '0;
            position_d = pos_step;
          end else begin
            tick_d = tick_eff + TICK_W'(1);
          end

          // dir above already used the old target, so a coincident sample
          // and step behave as if the sample came afterwards
          if (diff_q == DIFF_MIRROR) begin
            target_d = bus.ball_y;
            react_d  = '0;
          end else if (react_q == react_lim) begin
            target_d = bus.ball_y;
            react_d  = '0;
          end else begin
            react_d = react_q + REACT_W'(1);
          end
        end
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      diff_q        <= DIFF_EASY;
      position_q    <= RESET_Y;
      target_q      <= RESET_Y;
      tick_q        <= '0;
      react_q       <= '0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      diff_q        <= diff_d;
      position_q    <= position_d;
      target_q      <= target_d;
      tick_q        <= tick_d;
      react_q       <= react_d;
      moving_up_q   <= moving_up_d;
      moving_down_q <= moving_down_d;
    end
  end

  assign bus.position    = position_q;
  assign bus.target      = target_q;
  assign bus.moving_up   = moving_up_q;
  assign bus.moving_down = moving_down_q;

endmodule
`default_nettype wire

// File: doc/cpu_paddle_ctrl.md
# cpu_paddle_ctrl

Parametrised computer-player paddle controller with an integrated paddle position counter. It replaces the fixed-speed AI: per-difficulty speed and reaction delay, a deadband to stop jitter, optional screen wrap, and a mirror mode that copies the human's up/down inputs. It sits between the ball/physics logic, which supplies `ball_y`, and the renderer/collision logic, which consumes `position`.

## Interface
- `Y_W`, 10: width of all Y coordinates.
- `POS_MIN`, 32: lowest legal paddle-centre Y (top limit).
- `POS_MAX`, 447: highest legal paddle-centre Y (bottom limit).
- `POS_RESET`, 240: paddle-centre Y after reset.
- `DEADBAND`, 2: tracking modes issue no move while |target − position| ≤ DEADBAND.
- `TICK_W`, 20: width of the step-rate counter.
- `TICKS_MIRROR` / `TICKS_EASY` / `TICKS_MED` / `TICKS_HARD`, 20000 / 80000 / 40000 / 20000: cycles per 1-px step; each ≥1.
- `REACT_W`, 24: width of the reaction counter.
- `REACT_EASY` / `REACT_MED` / `REACT_HARD`, 2000000 / 1000000 / 250000: cycles between `ball_y` samples; each ≥1.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `game_on`  in  1: play enable; low = paddle frozen, difficulty may be changed.
- `diff`  in  2: 00 mirror, 01 easy, 10 medium, 11 hard.
- `ball_y`  in  Y_W: current ball-centre Y.
- `human_up`, `human_down`  in  1 each: human paddle commands, already synchronised; used in mirror mode only.
- `wrap_en`  in  1: 1 = wrap at the limits, 0 = clamp.
- `position`  out  Y_W: registered paddle-centre Y.
- `target`  out  Y_W: registered sampled ball Y, for debug.
- `moving_up`, `moving_down`  out  1 each: registered motion flags.

## Operation
- Up means decreasing Y.
- `diff_q` is the registered difficulty.
  - Loaded from `diff` on every cycle with `game_on`=0.
  - Held while `game_on`=1; a mid-game `diff` change takes effect only after `game_on` falls.
- State machine has two states.
  - IDLE: entered from reset, and whenever `game_on`=0. `position` is held, tick and reaction counters are cleared, motion flags are 0. IDLE→ACTIVE when `game_on`=1; on that edge `target` is loaded with `ball_y` and `react_cnt` is cleared.
  - ACTIVE: ACTIVE→IDLE on the first cycle with `game_on`=0.
- Reaction sampler, ACTIVE and tracking modes only:
  - `react_cnt` increments each cycle.
  - When it reaches REACT(diff_q)−1: `target` is loaded with `ball_y` and `react_cnt` returns to 0.
  - In mirror mode `target` follows `ball_y` every cycle.
- Direction `dir`, combinational:
  - Mirror mode: up if `human_up` and not `human_down`; down if `human_down` and not `human_up`; none if both or neither.
  - Tracking modes: up if target + DEADBAND < position; down if target > position + DEADBAND; else none.
  - Comparisons use Y_W+1 bits, no overflow.
- Blocking: `dir` is forced to none when `wrap_en`=0 and either position = POS_MIN with dir = up, or position = POS_MAX with dir = down.
- Step-rate counter:
  - `tick_cnt` increments while `dir` ≠ none.
  - It clears when `dir` = none, or when `dir` differs from the previous cycle's `dir`.
  - At TICKS(diff_q)−1 it clears and `position` steps by 1 in `dir`.
- Wrap, `wrap_en`=1: an up step from POS_MIN loads POS_MAX; a down step from POS_MAX loads POS_MIN.
- Out of range: if `position` is ever outside [POS_MIN, POS_MAX], the next step first loads the nearer limit.
- Motion flags: `moving_up`/`moving_down` are the registered post-block `dir`. The two are never both 1.

## Timing
- Reset values: `position`=POS_RESET, `target`=POS_RESET, `moving_up`=0, `moving_down`=0, `diff_q`=01, `tick_cnt`=0, `react_cnt`=0, state IDLE. Reset overrides `game_on` in the same cycle.
- `reset` asserted mid-motion: all of the above take effect on the next edge; no partial step completes.
- Motion flags lag `dir` by exactly 1 cycle.
- First step after `dir` becomes non-none in cycle 0 lands on the edge ending cycle TICKS−1. Steady rate is 1 px per TICKS cycles.
- `ball_y` change to `target` update: between 1 and REACT(diff_q) cycles.
- Direction reversal restarts the tick count; no step is carried over.
- Simultaneous reaction sample and step in the same cycle: the step uses the old `target`.

## Test plan
Bench parameters: TICKS_*=4, REACT_EASY/MED/HARD=16/8/4, DEADBAND=2, POS_MIN=10, POS_MAX=50, POS_RESET=30.
1. Reset, then hold `game_on`=0 for 20 cycles → `position`=30, `target`=30, both flags 0, `diff_q` tracks `diff`.
2. `diff`=11, `ball_y`=20, raise `game_on` → `target`=20 on the entry edge; `moving_up`=1 one cycle later; `position` 29 after 4 cycles and 28 after 8; stops at 22 (within deadband), `moving_up` then 0.
3. Hard mode, `ball_y` stepped 30→40 mid-game → `target` updates within 4 cycles; a pending up motion reverses and the first down step comes 4 cycles after the reversal.
4. Mirror mode, `position`=11, `wrap_en`=0, hold `human_up` → one step to 10, then `moving_up`=0 and `position` stays 10. Repeat with `wrap_en`=1 → sequence 11→10→50.
5. Mid-game `diff` 11→01 → no change in rate; drop `game_on` for 1 cycle and raise it again → reaction interval becomes 16 and `target` reloads on re-entry.
6. Assert `reset` while `position`=25 and moving → next cycle `position`=30, flags 0, state IDLE.
